// File: rtl/rf_dump_ctrl.sv
// -----------------------------------------------------------------------------
// rf_dump_ctrl
//   Walks a range of register-file addresses and presents each (addr, data)
//   pair on a valid/ready output port, one entry at a time. The range may wrap
//   past the top of the address space. The walk can be cancelled with abort.
//
// Ports
//   clk         in   clock, all state changes on rising edge
//   rstn        in   synchronous active-low reset
//   start       in   begin a dump (only looked at while idle)
//   abort       in   cancel the dump in progress
//   first_addr  in   first address of the range, captured with start
//   last_addr   in   last address of the range, captured with start
//   rf_ra       out  read address to the combinational register-file port
//   rf_rd       in   read data for rf_ra
//   out_valid   out  out_addr/out_data carry an entry
//   out_ready   in   consumer takes the entry when high together with out_valid
//   out_addr    out  address of the presented entry
//   out_data    out  data of the presented entry
//   busy        out  high whenever the controller is not idle
//   done        out  one-cycle pulse after the last entry has been taken
//   dbg_state_o out  current FSM state (IDLE=0, READ=1, OUT=2, FIN=3)
//
// Handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both high. out_valid, once raised, stays high with
// out_addr/out_data unchanged until that transfer (or an abort/reset);
// out_ready may be driven at any time and is ignored while out_valid is low.
// -----------------------------------------------------------------------------
module rf_dump_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    OUT  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [ADDR_W-1:0]   end_addr_q;
  logic [ADDR_W-1:0]   rf_ra_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                done_q;

  // Next address wraps naturally at 2^ADDR_W because of the fixed width.
  logic [ADDR_W-1:0]   cur_addr_d;

  always_comb begin
    cur_addr_d = cur_addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      end_addr_q  <= '0;
      rf_ra_q     <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // abort together with start keeps us idle.
          if (start && !abort) begin
            cur_addr_q <= first_addr;
            end_addr_q <= last_addr;
            // rf_ra is a register, so it is loaded on the way into READ
            // to be valid for the whole READ cycle.
            rf_ra_q    <= first_addr;
            busy_q     <= 1'b1;
            state_q    <= READ;
          end
        end

        READ: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            // Snapshot: later register-file writes cannot reach out_data.
            out_data_q  <= rf_rd;
            out_addr_q  <= cur_addr_q;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end

        OUT: begin
          if (abort) begin
            // Abort wins over a handshake in the same cycle.
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            if (cur_addr_q == end_addr_q) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              cur_addr_q <= cur_addr_d;
              rf_ra_q    <= cur_addr_d;
              state_q    <= READ;
            end
          end
        end

        FIN: begin
          // Leaves after one cycle whether or not abort is high; done only
          // lasts this one cycle in either case.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          out_valid_q <= 1'b0;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rf_ra       = rf_ra_q;
  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rf_dump_ctrl.sv
module tb_rf_dump_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rstn, start, abort, out_ready;
  logic [AW-1:0] first_addr, last_addr, rf_ra, out_addr;
  logic [DW-1:0] rf_rd, out_data;
  logic          out_valid, busy, done;
  logic [1:0]    dbg_state;

  logic [DW-1:0] rf [32];
  assign rf_rd = rf[rf_ra];

  always #5 clk = ~clk;

  rf_dump_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rf_ra(rf_ra), .rf_rd(rf_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by collect()
  logic [AW-1:0] got_addr_q[$];
  logic [DW-1:0] got_data_q[$];
  int first_valid, done_cyc, done_cnt, valid_cyc, hold_changes;

  function automatic logic [DW-1:0] rf_init(input int i);
    logic [DW-1:0] v;
    v = DW'(i) * 32'h1111_1111;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Runs the dump to completion. Cycle c=1 is the cycle after start was
  // accepted. out_ready stays low for the first ready_low valid cycles.
  task automatic collect(input int ready_low, input int budget);
    int low_left;
    logic [AW-1:0] held_a;
    logic [DW-1:0] held_d;
    got_addr_q.delete();
    got_data_q.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0; valid_cyc = 0; hold_changes = 0;
    low_left = ready_low;
    held_a = '0; held_d = '0;
    for (int c = 1; c <= budget; c++) begin
      if (out_valid) begin
        if (first_valid < 0) first_valid = c;
        if (valid_cyc > 0 && (out_addr !== held_a || out_data !== held_d)) hold_changes++;
        held_a = out_addr;
        held_d = out_data;
        valid_cyc++;
        out_ready = (low_left == 0);
        if (low_left > 0) low_left--;
        if (out_ready) begin
          got_addr_q.push_back(out_addr);
          got_data_q.push_back(out_data);
          valid_cyc = 0;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (!busy) break;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (rf_ra !== '0) begin n_fail++; $display("FAIL reset_rf_ra: got %0d want 0", rf_ra); end
    n_checks++; if (out_addr !== '0) begin n_fail++; $display("FAIL reset_out_addr: got %0d want 0", out_addr); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    start_dump(5'd3, 5'd6);
    n_checks++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL basic_read_at_t1: got %0d want 1", dbg_state); end
    n_checks++; if (rf_ra !== 5'd3) begin n_fail++; $display("FAIL basic_rf_ra: got %0d want 3", rf_ra); end
    collect(0, 30);
    n_checks++; if (first_valid !== 2) begin n_fail++; $display("FAIL basic_first_valid: got %0d want 2", first_valid); end
    n_checks++; if (done_cyc !== 9) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 9", done_cyc); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (got_addr_q.size() !== 4) begin n_fail++; $display("FAIL basic_entries: got %0d want 4", got_addr_q.size()); end
    for (int i = 0; i < 4 && i < got_addr_q.size(); i++) begin
      n_checks++; if (got_addr_q[i] !== AW'(3 + i)) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, got_addr_q[i], 3 + i); end
      n_checks++; if (got_data_q[i] !== rf_init(3 + i)) begin n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, got_data_q[i], rf_init(3 + i)); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: got busy %b want 0", busy); end
  endtask

  task automatic test_wrap();
    int exp_a[4];
    exp_a = '{30, 31, 0, 1};
    start_dump(5'd30, 5'd1);
    collect(0, 30);
    n_checks++; if (got_addr_q.size() !== 4) begin n_fail++; $display("FAIL wrap_entries: got %0d want 4", got_addr_q.size()); end
    for (int i = 0; i < 4 && i < got_addr_q.size(); i++) begin
      n_checks++; if (got_addr_q[i] !== AW'(exp_a[i])) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, got_addr_q[i], exp_a[i]); end
      n_checks++; if (got_data_q[i] !== rf_init(exp_a[i])) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, got_data_q[i], rf_init(exp_a[i])); end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_single_backpressure();
    out_ready = 1'b0;
    start_dump(5'd7, 5'd7);
    collect(5, 30);
    // valid from c=2..7, handshake on edge ending c=7, done at c=8
    n_checks++; if (got_addr_q.size() !== 1) begin n_fail++; $display("FAIL single_entries: got %0d want 1", got_addr_q.size()); end
    if (got_addr_q.size() > 0) begin
      n_checks++; if (got_addr_q[0] !== 5'd7) begin n_fail++; $display("FAIL single_addr: got %0d want 7", got_addr_q[0]); end
      n_checks++; if (got_data_q[0] !== 32'h7777_7777) begin n_fail++; $display("FAIL single_data: got %h want 77777777", got_data_q[0]); end
    end
    n_checks++; if (hold_changes !== 0) begin n_fail++; $display("FAIL single_hold_stable: got %0d changes want 0", hold_changes); end
    n_checks++; if (first_valid !== 2) begin n_fail++; $display("FAIL single_first_valid: got %0d want 2", first_valid); end
    n_checks++; if (done_cyc !== 8) begin n_fail++; $display("FAIL single_done_cycle: got %0d want 8 (6 valid cycles)", done_cyc); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    int hs;
    int dones;
    logic aborted;
    hs = 0; dones = 0; aborted = 1'b0;
    out_ready = 1'b1;
    start_dump(5'd0, 5'd31);
    for (int c = 1; c <= 20 && !aborted; c++) begin
      if (out_valid && out_ready) begin
        if (hs == 1) begin
          abort = 1'b1;
          aborted = 1'b1;
        end else begin
          hs++;
        end
      end
      if (done) dones++;
      tick();
    end
    abort = 1'b0;
    n_checks++; if (!aborted) begin n_fail++; $display("FAIL abort_reached: got no second handshake within budget"); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", out_valid); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL abort_state: got %0d want 0", dbg_state); end
    for (int c = 0; c < 4; c++) begin
      if (done) dones++;
      tick();
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
    n_checks++; if (hs !== 1) begin n_fail++; $display("FAIL abort_entries: got %0d want 1", hs); end
    // abort with start while idle must not begin a dump
    abort = 1'b1; start = 1'b1; first_addr = 5'd4; last_addr = 5'd4;
    tick();
    abort = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_start: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid_dump();
    out_ready = 1'b0;
    start_dump(5'd0, 5'd31);
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_addr !== 5'd0) begin n_fail++; $display("FAIL rst_mid_out: got valid %b addr %0d want 1/0", out_valid, out_addr); end
    first_addr = 5'd10; last_addr = 5'd12; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (dbg_state !== 2'd2 || out_addr !== 5'd0) begin n_fail++; $display("FAIL rst_mid_start_ignored: got state %0d addr %0d want 2/0", dbg_state, out_addr); end
    rstn = 1'b0; start = 1'b1; abort = 1'b1;
    tick();
    rstn = 1'b1; start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got busy %b done %b valid %b want 000", busy, done, out_valid); end
    n_checks++; if (rf_ra !== '0 || out_addr !== '0 || out_data !== '0) begin n_fail++; $display("FAIL rst_mid_regs: got ra %0d addr %0d data %h want 0", rf_ra, out_addr, out_data); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stays_idle: got busy %b want 0", busy); end
    out_ready = 1'b1;
    start_dump(5'd2, 5'd3);
    collect(0, 20);
    n_checks++; if (got_addr_q.size() !== 2) begin n_fail++; $display("FAIL rst_mid_restart_entries: got %0d want 2", got_addr_q.size()); end
    if (got_addr_q.size() == 2) begin
      n_checks++; if (got_addr_q[0] !== 5'd2 || got_addr_q[1] !== 5'd3) begin n_fail++; $display("FAIL rst_mid_restart_addr: got %0d,%0d want 2,3", got_addr_q[0], got_addr_q[1]); end
      n_checks++; if (got_data_q[1] !== 32'h3333_3333) begin n_fail++; $display("FAIL rst_mid_restart_data: got %h want 33333333", got_data_q[1]); end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rst_mid_restart_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_snapshot();
    out_ready = 1'b0;
    start_dump(5'd5, 5'd5);
    n_checks++; if (rf_ra !== 5'd5) begin n_fail++; $display("FAIL snap_rf_ra: got %0d want 5", rf_ra); end
    tick();
    rf[5] = 32'hDEAD_BEEF;   // write in the cycle after READ
    n_checks++; if (out_data !== 32'h5555_5555) begin n_fail++; $display("FAIL snap_data_now: got %h want 55555555", out_data); end
    tick();
    n_checks++; if (out_data !== 32'h5555_5555 || out_valid !== 1'b1) begin n_fail++; $display("FAIL snap_data_held: got %h valid %b want 55555555/1", out_data, out_valid); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL snap_done: got %b want 1", done); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL snap_done_pulse: got done %b busy %b want 0/0", done, busy); end
    rf[5] = rf_init(5);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = rf_init(i);
    test_reset();
    test_basic();
    test_wrap();
    test_single_backpressure();
    test_abort();
    test_reset_mid_dump();
    test_snapshot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_dump_ctrl.md
RF_DUMP_CTRL -- requirements
Module: rf_dump_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning the register-file address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the register-file data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 The block SHALL have port rstn, input, 1, reset that is synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1, request to begin a dump; sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1, cancel the dump in progress.
REQ-007 The block SHALL have port first_addr, input, ADDR_W, first address dumped; latched with start.
REQ-008 The block SHALL have port last_addr, input, ADDR_W, last address dumped; latched with start.
REQ-009 The block SHALL have port rf_ra, output, ADDR_W, read address driven to the combinational register-file read port.
REQ-010 The block SHALL have port rf_rd, input, DATA_W, combinational read data returned for rf_ra.
REQ-011 The block SHALL have port out_valid, output, 1, out_addr/out_data hold a valid entry.
REQ-012 The block SHALL have port out_ready, input, 1, consumer accepts the entry when high with out_valid.
REQ-013 The block SHALL have port out_addr, output, ADDR_W, address of the presented entry.
REQ-014 The block SHALL have port out_data, output, DATA_W, data of the presented entry.
REQ-015 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 The block SHALL have port done, output, 1, one-cycle pulse after the last entry is accepted.

Function
REQ-017 The FSM SHALL have states IDLE, READ, OUT and FIN.
REQ-018 In IDLE with start=1, the block SHALL latch first_addr into cur_addr and last_addr into end_addr, then move to READ.
REQ-019 In IDLE with start=0, the block SHALL stay in IDLE; start asserted in any other state SHALL be ignored.
REQ-020 In READ, rf_ra SHALL equal cur_addr, rf_rd SHALL be registered into out_data and cur_addr into out_addr, and the FSM SHALL move to OUT next cycle.
REQ-021 In OUT, out_valid SHALL be 1, and out_addr/out_data SHALL be held stable until the handshake (out_valid and out_ready high in the same cycle).
REQ-022 On a handshake, if cur_addr == end_addr the FSM SHALL go to FIN; otherwise cur_addr SHALL become (cur_addr+1) mod 2^ADDR_W and the FSM SHALL go to READ.
REQ-023 In FIN, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-024 Wrap-around: when first_addr > last_addr, addresses SHALL run through 2^ADDR_W-1, then 0, up to last_addr; entries dumped = ((last-first) mod 2^ADDR_W)+1.
REQ-025 When first_addr == last_addr, the block SHALL dump exactly one entry.
REQ-026 Latency: start accepted at cycle t SHALL give READ at t+1 and out_valid at t+2; with out_ready held high, each entry SHALL take 2 cycles.
REQ-027 out_data SHALL be a snapshot taken in the READ cycle; register-file writes after that cycle SHALL NOT alter the presented entry.
REQ-028 Outside READ, rf_ra SHALL hold its last driven value; out_valid SHALL be 0 outside OUT.
REQ-029 abort=1 in READ, OUT or FIN SHALL force IDLE next cycle with no handshake completing, no done pulse, and out_valid=0 from that next cycle; abort SHALL take priority over a simultaneous handshake.
REQ-030 abort in IDLE SHALL have no effect, and abort with start in IDLE SHALL NOT start a dump.

Reset
REQ-031 With rstn=0 at a posedge, the block SHALL enter IDLE with busy=0, done=0, out_valid=0, rf_ra=0, out_addr=0, out_data=0, cur_addr=0 and end_addr=0.
REQ-032 Reset mid-dump SHALL behave as abort, except that all registers SHALL also clear per REQ-031, and rstn SHALL take priority over start and abort.

Verification
REQ-033 The bench SHALL cover: RF preloaded with rf[i]=i*0x11111111, start with first=3, last=6, out_ready=1 -> entries (3,0x33333333)...(6,0x66666666), out_valid first at t+2, done at t+9.
REQ-034 The bench SHALL cover: first=30, last=1 -> out_addr sequence 30,31,0,1, exactly 4 handshakes, then one done pulse.
REQ-035 The bench SHALL cover: first=last=7, out_ready low 5 cycles then high -> out_valid held 6 cycles with out_addr=7 stable, one handshake, done next cycle.
REQ-036 The bench SHALL cover: abort in the same cycle as the second handshake of a 0..31 dump -> IDLE next cycle, busy=0, no done, only 1 entry counted.
REQ-037 The bench SHALL cover: rstn low during OUT, then start while busy (before the reset) -> start ignored; after reset all outputs zero; a new start works normally.
REQ-038 The bench SHALL cover: RF write to address 5 in the cycle after READ of address 5 -> out_data shows the old value.
